// File: rtl/loop_stack_if.sv
// Control-unit side of the nested-loop controller: loop instruction issue
// and the redirect / completion / status signals it produces.
interface loop_stack_if #(
  parameter int BITS    = 18,
  parameter int PC_BITS = 16,
  parameter int DEPTH   = 4
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic               start_valid;
  logic [BITS-1:0]    start_count;
  logic               start_independent;
  logic [PC_BITS-1:0] start_pc;
  logic               end_valid;
  logic               redirect_valid;
  logic [PC_BITS-1:0] redirect_pc;
  logic               loop_done;
  logic [BITS-1:0]    top_iteration;
  logic [DW-1:0]      depth;
  logic               overflow_err;
  logic               underflow_err;
  logic               protocol_err;

  modport master (
    output start_valid, start_count, start_independent, start_pc, end_valid,
    input  redirect_valid, redirect_pc, loop_done, top_iteration, depth,
           overflow_err, underflow_err, protocol_err
  );

  modport slave (
    input  start_valid, start_count, start_independent, start_pc, end_valid,
    output redirect_valid, redirect_pc, loop_done, top_iteration, depth,
           overflow_err, underflow_err, protocol_err
  );
endinterface

// File: rtl/loop_stack.sv
// Nested hardware-loop stack. start_loop pushes an entry; end_loop either
// advances the innermost loop and redirects to its body, or pops it.
// Each entry is idle/active purely by its position relative to depth.
module loop_stack #(
  parameter int BITS                  = 18,
  parameter int SUPERSCALAR_LOG_WIDTH = 2,
  parameter int DEPTH                 = 4,
  parameter int PC_BITS               = 16
) (
  input  logic        clk,
  input  logic        reset,
  loop_stack_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [BITS:0] STEP_ONE = (BITS + 1)'(1);
  localparam logic [BITS:0] STEP_IND = STEP_ONE << SUPERSCALAR_LOG_WIDTH;

  logic [BITS-1:0]    count_q [DEPTH];
  logic [BITS-1:0]    iter_q  [DEPTH];
  logic [PC_BITS-1:0] pc_q    [DEPTH];
  logic               ind_q   [DEPTH];
  logic [DW-1:0]      depth_q;

  logic               redirect_valid_q;
  logic [PC_BITS-1:0] redirect_pc_q;
  logic               loop_done_q;
  logic               overflow_q;
  logic               underflow_q;
  logic               protocol_q;

  logic [AW-1:0] top_idx;
  logic [AW-1:0] push_idx;
  logic          full;
  logic          empty;
  logic [BITS:0] step;
  logic [BITS:0] next_iter;

  // Top-of-stack view; the extra sum bit keeps iteration+step from wrapping.
  always_comb begin
    top_idx   = AW'(depth_q - DW'(1));
    push_idx  = AW'(depth_q);
    full      = (depth_q == DW'(DEPTH));
    empty     = (depth_q == '0);
    step      = ind_q[top_idx] ? STEP_IND : STEP_ONE;
    next_iter = {1'b0, iter_q[top_idx]} + step;
  end

  // Stack update, registered pulses and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        count_q[i] <= '0;
        iter_q[i]  <= '0;
        pc_q[i]    <= '0;
        ind_q[i]   <= 1'b0;
      end
      depth_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      loop_done_q      <= 1'b0;
      overflow_q       <= 1'b0;
      underflow_q      <= 1'b0;
      protocol_q       <= 1'b0;
    end else begin
      redirect_valid_q <= 1'b0;
      loop_done_q      <= 1'b0;
      if (bus.start_valid && bus.end_valid) begin
        protocol_q <= 1'b1;
      end else if (bus.start_valid) begin
        if (full) begin
          overflow_q <= 1'b1;
        end else begin
          // A zero count still executes the body once.
          count_q[push_idx] <= (bus.start_count == '0) ? BITS'(1) : bus.start_count;
          iter_q[push_idx]  <= '0;
          pc_q[push_idx]    <= bus.start_pc;
          ind_q[push_idx]   <= bus.start_independent;
          depth_q           <= depth_q + DW'(1);
        end
      end else if (bus.end_valid) begin
        if (empty) begin
          underflow_q <= 1'b1;
        end else if (next_iter < {1'b0, count_q[top_idx]}) begin
          iter_q[top_idx]  <= next_iter[BITS-1:0];
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= pc_q[top_idx];
        end else begin
          depth_q     <= depth_q - DW'(1);
          loop_done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.loop_done      = loop_done_q;
  assign bus.top_iteration  = empty ? '0 : iter_q[top_idx];
  assign bus.depth          = depth_q;
  assign bus.overflow_err   = overflow_q;
  assign bus.underflow_err  = underflow_q;
  assign bus.protocol_err   = protocol_q;
endmodule

// File: tb/tb_loop_stack.sv
// Directed bench for loop_stack: single, independent, nested, full/empty,
// protocol error and asynchronous reset scenarios.
module tb_loop_stack;
  localparam int BITS    = 18;
  localparam int PC_BITS = 16;
  localparam int DEPTH   = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  loop_stack_if #(.BITS(BITS), .PC_BITS(PC_BITS), .DEPTH(DEPTH)) bus ();

  loop_stack #(
    .BITS(BITS),
    .SUPERSCALAR_LOG_WIDTH(2),
    .DEPTH(DEPTH),
    .PC_BITS(PC_BITS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int cnt, input int pc, input logic ind);
    bus.start_valid       = 1'b1;
    bus.start_count       = BITS'(cnt);
    bus.start_pc          = PC_BITS'(pc);
    bus.start_independent = ind;
    cyc();
    bus.start_valid       = 1'b0;
  endtask

  task automatic end_loop();
    bus.end_valid = 1'b1;
    cyc();
    bus.end_valid = 1'b0;
  endtask

  task automatic check_redirect(input string tag, input int pc, input int iter);
    check({tag, "_rv"}, 32'(bus.redirect_valid), 1);
    check({tag, "_pc"}, 32'(bus.redirect_pc), pc);
    check({tag, "_ld"}, 32'(bus.loop_done), 0);
    check({tag, "_it"}, 32'(bus.top_iteration), iter);
  endtask

  task automatic check_done(input string tag, input int dep, input int iter);
    check({tag, "_ld"}, 32'(bus.loop_done), 1);
    check({tag, "_rv"}, 32'(bus.redirect_valid), 0);
    check({tag, "_dp"}, 32'(bus.depth), dep);
    check({tag, "_it"}, 32'(bus.top_iteration), iter);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rv"}, 32'(bus.redirect_valid), 0);
    check({tag, "_ld"}, 32'(bus.loop_done), 0);
    check({tag, "_dp"}, 32'(bus.depth), 0);
    check({tag, "_it"}, 32'(bus.top_iteration), 0);
    check({tag, "_ov"}, 32'(bus.overflow_err), 0);
    check({tag, "_un"}, 32'(bus.underflow_err), 0);
    check({tag, "_pr"}, 32'(bus.protocol_err), 0);
  endtask

  // Linear directed sequence.
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.start_valid       = 1'b0;
    bus.start_count       = '0;
    bus.start_independent = 1'b0;
    bus.start_pc          = '0;
    bus.end_valid         = 1'b0;

    // Reset held with inputs toggling.
    bus.start_valid = 1'b1;
    bus.start_count = BITS'(7);
    cyc();
    bus.start_valid = 1'b0;
    bus.end_valid   = 1'b1;
    cyc();
    bus.end_valid   = 1'b0;
    check_idle_outputs("rst_hold");
    reset = 1'b1;
    cyc();
    check_idle_outputs("rst_rel");

    // Simple loop: count 3, ends spaced four cycles.
    push(3, 'h40, 1'b0);
    check("simple_push_dp", 32'(bus.depth), 1);
    check("simple_push_it", 32'(bus.top_iteration), 0);
    end_loop();
    check_redirect("simple_e1", 'h40, 1);
    cyc();
    check("simple_e1_pulse_once", 32'(bus.redirect_valid), 0);
    cyc(); cyc();
    end_loop();
    check_redirect("simple_e2", 'h40, 2);
    cyc(); cyc(); cyc();
    end_loop();
    check_done("simple_e3", 0, 0);
    cyc();
    check("simple_e3_pulse_once", 32'(bus.loop_done), 0);

    // Independent loop, count 12: step 4.
    push(12, 'h80, 1'b1);
    end_loop();
    check_redirect("ind12_e1", 'h80, 4);
    cyc();
    end_loop();
    check_redirect("ind12_e2", 'h80, 8);
    cyc();
    end_loop();
    check_done("ind12_e3", 0, 0);

    // Independent loop, count 10, back-to-back ends: 8+4 >= 10 finishes.
    push(10, 'h90, 1'b1);
    bus.end_valid = 1'b1;
    cyc();
    check_redirect("ind10_e1", 'h90, 4);
    cyc();
    check_redirect("ind10_e2", 'h90, 8);
    cyc();
    bus.end_valid = 1'b0;
    check_done("ind10_e3", 0, 0);

    // Zero count runs the body exactly once.
    push(0, 'h55, 1'b0);
    end_loop();
    check_done("zero_cnt", 0, 0);

    // Nested loops.
    push(2, 'h10, 1'b0);
    push(2, 'h20, 1'b0);
    check("nest_dp2", 32'(bus.depth), 2);
    end_loop();
    check_redirect("nest_e1", 'h20, 1);
    end_loop();
    check_done("nest_e2", 1, 0);
    end_loop();
    check_redirect("nest_e3", 'h10, 1);
    push(2, 'h20, 1'b0);
    check("nest_repush_dp", 32'(bus.depth), 2);
    check("nest_repush_it", 32'(bus.top_iteration), 0);
    end_loop();
    check_redirect("nest_e4", 'h20, 1);
    end_loop();
    check_done("nest_e5", 1, 1);
    end_loop();
    check_done("nest_e6", 0, 0);

    // Fill the stack and overflow it.
    for (int i = 0; i < 4; i++) push(1, 'h100 + i, 1'b0);
    check("full_dp", 32'(bus.depth), 4);
    check("full_ov_before", 32'(bus.overflow_err), 0);
    push(9, 'h200, 1'b0);
    check("ovf_dp", 32'(bus.depth), 4);
    check("ovf_flag", 32'(bus.overflow_err), 1);
    check("ovf_it", 32'(bus.top_iteration), 0);

    // Simultaneous start and end: ignored, protocol error set.
    bus.start_valid = 1'b1;
    bus.start_count = BITS'(3);
    bus.end_valid   = 1'b1;
    cyc();
    bus.start_valid = 1'b0;
    bus.end_valid   = 1'b0;
    check("proto_flag", 32'(bus.protocol_err), 1);
    check("proto_dp", 32'(bus.depth), 4);
    check("proto_ld", 32'(bus.loop_done), 0);
    check("proto_rv", 32'(bus.redirect_valid), 0);

    // Drain and underflow.
    end_loop();
    check_done("drain1", 3, 0);
    end_loop();
    check_done("drain2", 2, 0);
    end_loop();
    check_done("drain3", 1, 0);
    end_loop();
    check_done("drain4", 0, 0);
    check("drain_un_before", 32'(bus.underflow_err), 0);
    end_loop();
    check("unf_flag", 32'(bus.underflow_err), 1);
    check("unf_ld", 32'(bus.loop_done), 0);
    check("unf_rv", 32'(bus.redirect_valid), 0);
    check("unf_dp", 32'(bus.depth), 0);
    check("sticky_ov", 32'(bus.overflow_err), 1);
    check("sticky_pr", 32'(bus.protocol_err), 1);

    // Reset clears sticky flags; then async reset mid-loop.
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    check_idle_outputs("rst2");
    push(5, 'h30, 1'b0);
    push(5, 'h34, 1'b0);
    end_loop();
    check("mid_dp", 32'(bus.depth), 2);
    check("mid_it", 32'(bus.top_iteration), 1);
    #3;
    reset = 1'b0;
    #1;
    check("async_dp", 32'(bus.depth), 0);
    check("async_it", 32'(bus.top_iteration), 0);
    check("async_rv", 32'(bus.redirect_valid), 0);
    cyc();
    reset = 1'b1;
    cyc();
    end_loop();
    check("post_rst_un", 32'(bus.underflow_err), 1);
    check("post_rst_ld", 32'(bus.loop_done), 0);
    check("post_rst_rv", 32'(bus.redirect_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/loop_stack.md
# loop_stack

Nested-loop controller in the control unit, directly upstream of the per-loop iteration logic. It tracks up to DEPTH nested hardware loops opened by start_loop instructions and closed by end_loop instructions. On each end_loop it either issues a branch redirect to the loop body start or pops the loop and lets execution fall through. It exports the innermost loop's iteration index for address generation.

## Interface
- BITS, 18, width of iteration counts and indices
- SUPERSCALAR_LOG_WIDTH, 2, log2 of the iteration step for inner independent loops
- DEPTH, 4, maximum nesting depth (power of two, ≥2)
- PC_BITS, 16, program counter width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- start_valid  input  1  start_loop instruction issued this cycle
- start_count  input  BITS  total iteration count of the new loop
- start_independent  input  1  new loop is an inner independent loop
- start_pc  input  PC_BITS  PC of the first body instruction
- end_valid  input  1  end_loop instruction issued this cycle
- redirect_valid  output  1  one-cycle pulse: branch to redirect_pc
- redirect_pc  output  PC_BITS  loop body start PC, valid with redirect_valid
- loop_done  output  1  one-cycle pulse: innermost loop completed and popped
- top_iteration  output  BITS  current iteration index of the innermost loop, 0 when empty
- depth  output  $clog2(DEPTH)+1  number of active loops
- overflow_err  output  1  sticky: start_loop with stack full
- underflow_err  output  1  sticky: end_loop with stack empty
- protocol_err  output  1  sticky: start_valid and end_valid in the same cycle

## Operation
- Each stack entry holds count (BITS), iteration (BITS), start PC (PC_BITS), and the independent flag. Entries are registers with no memory macro.
- step = 1 << SUPERSCALAR_LOG_WIDTH for independent entries, 1 otherwise.
- start_valid with depth<DEPTH: push {count, 0, start_pc, independent}; depth+1. start_count 0 is stored as 1, so the body always runs once.
- end_valid with depth>0, top entry:
  - if iteration+step < count: iteration += step; redirect_valid=1, redirect_pc=top start PC.
  - otherwise: pop; depth−1; loop_done=1; no redirect.
- Compare iteration+step in BITS+1 bits; no wrap. A count not a multiple of step completes on the first end_loop where iteration+step ≥ count.
- Errors:
  - start_valid at depth==DEPTH: ignored; overflow_err set.
  - end_valid at depth==0: ignored; underflow_err set.
  - start_valid and end_valid together: both ignored; protocol_err set.
  - Error flags clear only on reset.
- Two-state control per entry (idle/active), implied by depth; no other FSM state.

## Timing
- Reset (async assert, released synchronously by the environment): depth=0, top_iteration=0, redirect_valid=0, redirect_pc=0, loop_done=0, all error flags=0, all entries zeroed. Assertion mid-loop discards all loops immediately without waiting for a clock.
- Push: start_valid sampled at edge N; depth and top_iteration=0 visible after edge N.
- End: end_valid sampled at edge N. redirect_valid/redirect_pc or loop_done are registered and high for exactly the cycle after edge N. The updated top_iteration, or the parent's index after a pop, is visible after edge N.
- Back-to-back end_valid on consecutive cycles is legal; each is evaluated against state updated by the previous edge.
- Pulses never stay high two cycles without a new end_valid.

## Test plan
- Reset: hold reset low 2 cycles with inputs toggling -> all outputs 0; release -> still 0.
- Simple loop: push count 3, pc 0x40, non-independent; 3 end_valids spaced 4 cycles -> first two give redirect_valid pulse with pc 0x40, top_iteration 1 then 2; third gives loop_done, depth 0, top_iteration 0.
- Independent loop: count 12, independent -> end 1 and end 2 redirect, top_iteration 4 then 8; end 3 gives loop_done. Count 10 independent -> loop_done on end 3 (8+4≥10).
- Nested: outer count 2 pc 0x10, inner count 2 pc 0x20 -> end sequence: redirect 0x20; done (depth 1, top_iteration 0); redirect 0x10 (top_iteration 1); re-push inner, redirect 0x20, done; done -> depth 0.
- Full/empty: 5 pushes with DEPTH 4 -> depth 4, overflow_err 1, 5th ignored. Pop all, then one more end_valid -> underflow_err 1, no pulse. start_valid+end_valid together -> protocol_err 1, state unchanged.
- Reset mid-operation: depth 2, iteration 1; drop reset between edges -> depth and top_iteration 0 immediately; next end_valid after release -> underflow_err 1.
